// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg -- shared definitions for the traffic-light lamp monitor.
//   * 2-bit light codes (green / yellow / red / invalid)
//   * monitor state encodings
//   * fault_code values
//   * permitted non-red pair mask and a conflict-detect helper
// Approach index order everywhere: 0=M1, 1=M2, 2=M3, 3=M4, 4=R, 5=S.
// ---------------------------------------------------------------------------
package tlc_pkg;

    localparam int N_APP = 6;

    typedef enum logic [1:0] {
        CODE_RED = 2'b00,
        CODE_YEL = 2'b01,
        CODE_GRN = 2'b10,
        CODE_INV = 2'b11
    } light_code_e;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_FLASH   = 2'd1,
        ST_RECOVER = 2'd2,
        ST_ILLEGAL = 2'd3
    } mon_state_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_INVALID  = 3'd2,
        FC_YSKIP    = 3'd3
    } fault_code_e;

    // Row i, bit j set: approaches i and j may be non-red together.
    // Allowed pairs: {M1,M2}, {M1,M3}, {M2,M4}; the matrix is symmetric.
    localparam logic [N_APP-1:0][N_APP-1:0] PAIR_OK = {
        6'b000000,  // S
        6'b000000,  // R
        6'b000010,  // M4 : M2
        6'b000001,  // M3 : M1
        6'b001001,  // M2 : M1, M4
        6'b000110   // M1 : M2, M3
    };

    // True when any two non-red approaches form a pair outside PAIR_OK.
    function automatic logic has_conflict(input logic [N_APP-1:0] nonred);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_APP; i++) begin
            for (int j = 0; j < N_APP; j++) begin
                if (i != j && nonred[i] && nonred[j] && !PAIR_OK[i][j]) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/tlc_cycle_timer.sv
// ---------------------------------------------------------------------------
// tlc_cycle_timer -- saturating cycle timer for the flash phase / all-red hold.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (count -> 0)
//   load_i       restart; the loading edge counts as the first cycle (count=1)
//   enable_i     advance the count by one per cycle, saturating at limit_i
//   limit_i      phase length in cycles
//   done_o       count has reached limit_i
// ---------------------------------------------------------------------------
module tlc_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assigned first so every path drives cnt_d -- no latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(1);
        end else if (enable_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q >= limit_i);

endmodule

// File: rtl/tlc_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tlc_lamp_monitor -- conflict monitor for a six-approach signal controller.
// Registers the controller's light codes, drives one lamp per approach in
// NORMAL, flashes all reds in FLASH after a filtered violation, and holds
// solid all-red in RECOVER before returning to NORMAL.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (-> RECOVER)
//   light_in[11:0] six 2-bit codes {S,R,M4,M3,M2,M1}, M1 at [1:0]
//   clr            fault clear request (FLASH -> RECOVER when no violation)
//   lamp_r/y/g     per-approach lamp drives, bit i = approach i
//   fault          high while in FLASH
//   fault_code     cause of the latched fault (tlc_pkg::fault_code_e)
//   mon_state      current state (tlc_pkg::mon_state_e)
// Build option: define TLC_MON_YELLOW_CHECK_EN to add the yellow-skip check.
// ---------------------------------------------------------------------------
module tlc_lamp_monitor
    import tlc_pkg::*;
#(
    parameter int FAULT_FILT  = 2,
    parameter int FLASH_HALF  = 4,
    parameter int ALL_RED_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*N_APP-1:0]   light_in,
    input  logic                 clr,
    output logic [N_APP-1:0]     lamp_r,
    output logic [N_APP-1:0]     lamp_y,
    output logic [N_APP-1:0]     lamp_g,
    output logic                 fault,
    output logic [2:0]           fault_code,
    output logic [1:0]           mon_state
);

    localparam int FW   = $clog2(FAULT_FILT + 1);
    localparam int TMAX = (FLASH_HALF > ALL_RED_CYC) ? FLASH_HALF : ALL_RED_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    logic [2*N_APP-1:0] light_q;
    mon_state_e         state_q, state_d;
    fault_code_e        code_q, code_d;
    logic [FW-1:0]      filt_q, filt_d;
    logic               flash_q, flash_d;

    logic [N_APP-1:0]   nonred, inval;
    logic               viol_conflict, viol_invalid, viol_skip, any_viol;
    fault_code_e        viol_code;
    logic               tmr_load, tmr_en, tmr_done;
    logic [TW-1:0]      tmr_limit;

    // ---- violation detection on the registered codes ----
    always_comb begin
        nonred = '0;
        inval  = '0;
        for (int i = 0; i < N_APP; i++) begin
            nonred[i] = (light_q[2*i +: 2] != CODE_RED);
            inval[i]  = (light_q[2*i +: 2] == CODE_INV);
        end
    end

    assign viol_conflict = has_conflict(nonred);
    assign viol_invalid  = |inval;

`ifdef TLC_MON_YELLOW_CHECK_EN
    // prev_q keeps each approach's code from before its most recent change,
    // so a green->red skip stays flagged until that approach changes again.
    logic [2*N_APP-1:0] prev_q, prev_d;
    logic [N_APP-1:0]   skip;

    always_comb begin
        prev_d = prev_q;
        skip   = '0;
        for (int i = 0; i < N_APP; i++) begin
            if (light_in[2*i +: 2] != light_q[2*i +: 2]) begin
                prev_d[2*i +: 2] = light_q[2*i +: 2];
            end
            skip[i] = (prev_q[2*i +: 2] == CODE_GRN) && (light_q[2*i +: 2] == CODE_RED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign viol_skip = |skip;
`else
    assign viol_skip = 1'b0;
`endif

    assign any_viol  = viol_invalid | viol_conflict | viol_skip;
    assign viol_code = viol_invalid  ? FC_INVALID  :
                       viol_conflict ? FC_CONFLICT :
                       viol_skip     ? FC_YSKIP    : FC_NONE;

    // ---- shared flash-phase / all-red hold timer ----
    assign tmr_limit = (state_q == ST_FLASH) ? TW'(FLASH_HALF) : TW'(ALL_RED_CYC);

    tlc_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .enable_i (tmr_en),
        .limit_i  (tmr_limit),
        .done_o   (tmr_done)
    );

    // ---- next-state logic ----
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        filt_d   = '0;
        flash_d  = flash_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (any_viol) begin
                    filt_d = (filt_q == FW'(FAULT_FILT)) ? filt_q : filt_q + FW'(1);
                end
                // The edge on which the count reaches FAULT_FILT is the FLASH entry edge.
                if (any_viol && (filt_q >= FW'(FAULT_FILT - 1))) begin
                    state_d  = ST_FLASH;
                    code_d   = viol_code;
                    flash_d  = 1'b1;
                    tmr_load = 1'b1;
                    filt_d   = '0;
                end
            end
            ST_FLASH: begin
                tmr_en = 1'b1;
                if (clr && !any_viol) begin
                    state_d  = ST_RECOVER;
                    tmr_load = 1'b1;
                end else if (tmr_done) begin
                    flash_d  = ~flash_q;
                    tmr_load = 1'b1;
                end
            end
            ST_RECOVER: begin
                tmr_en = 1'b1;
                if (any_viol) begin
                    state_d  = ST_FLASH;
                    code_d   = viol_code;
                    flash_d  = 1'b1;
                    tmr_load = 1'b1;
                end else if (tmr_done) begin
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d  = ST_FLASH;
                flash_d  = 1'b1;
                tmr_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_q <= '0;
            state_q <= ST_RECOVER;
            code_q  <= FC_NONE;
            filt_q  <= '0;
            flash_q <= 1'b0;
        end else begin
            light_q <= light_in;
            state_q <= state_d;
            code_q  <= code_d;
            filt_q  <= filt_d;
            flash_q <= flash_d;
        end
    end

    // ---- lamp outputs ----
    always_comb begin
        lamp_r = '0;
        lamp_y = '0;
        lamp_g = '0;
        fault  = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                for (int i = 0; i < N_APP; i++) begin
                    if (light_q[2*i +: 2] == CODE_GRN) begin
                        lamp_g[i] = 1'b1;
                    end else if (light_q[2*i +: 2] == CODE_YEL) begin
                        lamp_y[i] = 1'b1;
                    end else begin
                        // Invalid codes fall back to red.
                        lamp_r[i] = 1'b1;
                    end
                end
            end
            ST_FLASH: begin
                lamp_r = {N_APP{flash_q}};
                fault  = 1'b1;
            end
            default: begin
                lamp_r = '1;
            end
        endcase
    end

    assign fault_code = code_q;
    assign mon_state  = state_q;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tb_tlc_lamp_monitor -- scoreboard bench for tlc_lamp_monitor.
// The stimulus thread drives inputs just after each falling edge and queues
// the expected outputs tagged with the cycle they must appear in; the monitor
// samples the DUT on every falling edge and retires entries due that cycle.
// Cycle number = count of rising edges seen so far.
// ---------------------------------------------------------------------------
module tb_tlc_lamp_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] light_in;
    logic        clr;
    logic [5:0]  lamp_r, lamp_y, lamp_g;
    logic        fault;
    logic [2:0]  fault_code;
    logic [1:0]  mon_state;

    tlc_lamp_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .light_in   (light_in),
        .clr        (clr),
        .lamp_r     (lamp_r),
        .lamp_y     (lamp_y),
        .lamp_g     (lamp_g),
        .fault      (fault),
        .fault_code (fault_code),
        .mon_state  (mon_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] st;
        logic [5:0] r;
        logic [5:0] y;
        logic [5:0] g;
        logic       f;
        logic [2:0] code;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) sync();
    endtask

    task automatic push(input int off, input string name, input logic [1:0] st,
                        input logic [5:0] r, input logic [5:0] y, input logic [5:0] g,
                        input logic f, input logic [2:0] code);
        exp_t e;
        e.at   = cyc + off;
        e.st   = st;
        e.r    = r;
        e.y    = y;
        e.g    = g;
        e.f    = f;
        e.code = code;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp_norm(input int off, input string name, input logic [5:0] r,
                            input logic [5:0] y, input logic [5:0] g, input logic [2:0] code);
        push(off, name, 2'd0, r, y, g, 1'b0, code);
    endtask

    task automatic exp_flash(input int off, input string name, input logic on,
                             input logic [2:0] code);
        push(off, name, 2'd1, {6{on}}, 6'h00, 6'h00, 1'b1, code);
    endtask

    task automatic exp_rec(input int off, input string name, input logic [2:0] code);
        push(off, name, 2'd2, 6'h3F, 6'h00, 6'h00, 1'b0, code);
    endtask

    // Monitor: retire every expectation due at the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (e.at != cyc) begin
                    bad++;
                    $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.at);
                end else if (mon_state !== e.st || lamp_r !== e.r || lamp_y !== e.y ||
                             lamp_g !== e.g || fault !== e.f || fault_code !== e.code) begin
                    bad++;
                    $display("FAIL %s @%0d: got st=%0d r=%b y=%b g=%b f=%b code=%0d, want st=%0d r=%b y=%b g=%b f=%b code=%0d",
                             e.name, cyc, mon_state, lamp_r, lamp_y, lamp_g, fault, fault_code,
                             e.st, e.r, e.y, e.g, e.f, e.code);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        light_in = 12'h000;
        clr      = 1'b0;

        // Reset state, then release with M1+M2 green: 8 all-red cycles, then NORMAL.
        sync();
        exp_rec(1, "reset_state", 3'd0);
        sync();
        light_in = 12'h00A;
        rst_n    = 1'b1;
        for (int k = 1; k <= 8; k++) exp_rec(k, "reset_allred", 3'd0);
        exp_norm(9, "reset_to_normal", 6'h3C, 6'h00, 6'h03, 3'd0);
        wait_cyc(9);

        // Single-cycle conflicts (M4 yellow with M1) separated by a clean cycle.
        light_in = 12'h04A;
        exp_norm(1, "glitch1_lamps", 6'h34, 6'h08, 6'h03, 3'd0);
        sync();
        light_in = 12'h00A;
        exp_norm(1, "glitch1_gone", 6'h3C, 6'h00, 6'h03, 3'd0);
        sync();
        light_in = 12'h04A;
        exp_norm(1, "glitch2_lamps", 6'h34, 6'h08, 6'h03, 3'd0);
        sync();
        light_in = 12'h00A;
        exp_norm(1, "filter_cleared", 6'h3C, 6'h00, 6'h03, 3'd0);
        exp_norm(3, "no_fault_later", 6'h3C, 6'h00, 6'h03, 3'd0);
        wait_cyc(3);

        // M1 and M4 green together, held: FLASH with code 1, reds toggle every 4.
        light_in = 12'h08A;
        exp_norm(1, "conflict_c1", 6'h34, 6'h00, 6'h0B, 3'd0);
        exp_norm(2, "conflict_c2", 6'h34, 6'h00, 6'h0B, 3'd0);
        exp_flash(3, "flash_enter", 1'b1, 3'd1);
        exp_flash(6, "flash_on_end", 1'b1, 3'd1);
        exp_flash(7, "flash_off_start", 1'b0, 3'd1);
        exp_flash(10, "flash_off_end", 1'b0, 3'd1);
        exp_flash(11, "flash_on_again", 1'b1, 3'd1);
        wait_cyc(11);

        // clr while the conflict persists is ignored; clr once clean -> RECOVER.
        clr = 1'b1;
        exp_flash(1, "clr_ignored", 1'b1, 3'd1);
        sync();
        clr      = 1'b0;
        light_in = 12'h04A;
        exp_flash(1, "flash_m4_yellow", 1'b1, 3'd1);
        sync();
        light_in = 12'h00A;
        exp_flash(1, "flash_clean", 1'b1, 3'd1);
        sync();
        clr = 1'b1;
        for (int k = 1; k <= 8; k++) exp_rec(k, "clr_recover", 3'd1);
        exp_norm(9, "recover_done", 6'h3C, 6'h00, 6'h03, 3'd1);
        sync();
        clr = 1'b0;
        wait_cyc(8);

        // M2 invalid together with a conflict: invalid wins.
        light_in = 12'h08E;
        exp_norm(1, "invalid_c1", 6'h36, 6'h00, 6'h09, 3'd1);
        exp_norm(2, "invalid_c2", 6'h36, 6'h00, 6'h09, 3'd1);
        exp_flash(3, "invalid_latch", 1'b1, 3'd2);
        wait_cyc(3);
        light_in = 12'h04A;
        exp_flash(1, "inv_flash_a", 1'b1, 3'd2);
        sync();
        light_in = 12'h00A;
        exp_flash(1, "inv_flash_b", 1'b1, 3'd2);
        sync();
        clr = 1'b1;
        exp_rec(1, "inv_recover", 3'd2);
        sync();
        // A violation during RECOVER returns to FLASH at once with the new code.
        clr      = 1'b0;
        light_in = 12'h04A;
        exp_rec(1, "recover_clean_cyc", 3'd2);
        exp_flash(2, "recover_violation", 1'b1, 3'd1);
        sync();
        light_in = 12'h00A;
        sync();
        clr = 1'b1;
        for (int k = 1; k <= 8; k++) exp_rec(k, "recover2_hold", 3'd1);
        exp_norm(9, "recover2_done", 6'h3C, 6'h00, 6'h03, 3'd1);
        sync();
        clr = 1'b0;
        wait_cyc(8);

        // M1 green -> red with no yellow, held.
        light_in = 12'h008;
        exp_norm(1, "yskip_c1", 6'h3D, 6'h00, 6'h02, 3'd1);
        exp_norm(2, "yskip_c2", 6'h3D, 6'h00, 6'h02, 3'd1);
`ifdef TLC_MON_YELLOW_CHECK_EN
        exp_flash(3, "yskip_latch", 1'b1, 3'd3);
        exp_flash(5, "yskip_hold", 1'b1, 3'd3);
`else
        exp_norm(3, "yskip_off_c3", 6'h3D, 6'h00, 6'h02, 3'd1);
        exp_norm(5, "yskip_off_c5", 6'h3D, 6'h00, 6'h02, 3'd1);
`endif
        // Reset asserted between edges must take effect before the next edge.
        exp_rec(6, "async_reset", 3'd0);
        wait_cyc(5);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        light_in = 12'h00A;
        sync();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) exp_rec(k, "reset2_allred", 3'd0);
        exp_norm(9, "reset2_normal", 6'h3C, 6'h00, 6'h03, 3'd0);
        wait_cyc(9);

        for (int k = 0; k < 50 && sb.size() > 0; k++) sync();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlc_lamp_monitor.md
TLC_LAMP_MONITOR -- requirements
Module: tlc_lamp_monitor

Interface
REQ-001 Parameter FAULT_FILT, default 2: consecutive cycles a violation must persist before it is latched.
REQ-002 Parameter FLASH_HALF, default 4: half-period of the fault flash, in cycles.
REQ-003 Parameter ALL_RED_CYC, default 8: solid all-red hold after a fault clear, in cycles.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 light_in  input  12  six 2-bit light codes, packed {S,R,M4,M3,M2,M1}, M1 at [1:0]; code 10 = green, 01 = yellow, 00 = red, 11 = invalid.
REQ-007 clr  input  1  fault clear request, sampled on the rising edge.
REQ-008 lamp_r / lamp_y / lamp_g  output  6 each  one-hot lamp drives per approach, bit i = approach i.
REQ-009 fault  output  1  high while in FLASH.
REQ-010 fault_code  output  3  cause of the latched fault.
REQ-011 mon_state  output  2  current state.

Function
REQ-012 light_in SHALL be registered once; all checks and lamp outputs SHALL use the registered copy, giving 1-cycle input-to-lamp latency in NORMAL.
REQ-013 In NORMAL, each approach SHALL drive exactly one lamp: green for 10, yellow for 01, red for 00.
REQ-014 The permitted non-red pairs SHALL be {M1,M2}, {M1,M3} and {M2,M4}; any other two approaches non-red together SHALL be a conflict violation (fault_code 1).
REQ-015 Any code 11 SHALL be an invalid violation (fault_code 2).
REQ-016 Any direct change from 10 to 00 on any approach SHALL be a yellow-skip violation (fault_code 3), gated per REQ-026.
REQ-017 A filter counter SHALL increment on each cycle with any violation and clear to 0 on any violation-free cycle; when it reaches FAULT_FILT, the block SHALL enter FLASH on the next edge.
REQ-018 The latched fault_code SHALL be the highest-priority active violation at latch time, priority invalid > conflict > yellow-skip.
REQ-019 States: NORMAL = 0, FLASH = 1, RECOVER = 2; encoding 3 SHALL return to FLASH.
REQ-020 In FLASH: lamp_g = 0, lamp_y = 0, and all six lamp_r bits SHALL toggle together every FLASH_HALF cycles, starting at on.
REQ-021 In FLASH, clr = 1 with no violation in the same cycle SHALL move to RECOVER; clr with a violation present SHALL be ignored.
REQ-022 In RECOVER: lamp_r = all ones; after ALL_RED_CYC cycles, go to NORMAL with the filter counter cleared; any violation during RECOVER SHALL return to FLASH immediately with fault_code updated.
REQ-023 Counters SHALL saturate and never wrap; the flash counter resets on entry to FLASH.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously force the following, regardless of current operation: state RECOVER, lamp_r = 6'h3F, lamp_y = 0, lamp_g = 0, fault = 0, fault_code = 0, registered input = 0, all counters = 0.
REQ-025 On release of reset, the block SHALL complete the ALL_RED_CYC hold before entering NORMAL.

Configuration
REQ-026 Macro TLC_MON_YELLOW_CHECK_EN: when defined, REQ-016 is active; when undefined, the yellow-skip check and its previous-code register SHALL be absent, and fault_code 3 SHALL never occur.

Structure
REQ-027 A shared package tlc_pkg SHALL hold the light-code constants, state encodings, fault_code values and the permitted-pair mask.
REQ-028 The flash/hold timer SHALL be a sub-module tlc_cycle_timer (load, enable, done).

Verification
REQ-029 Reset release with light_in = 12'h00A -> lamp_r = 3F for 8 cycles, then lamp_g = 000011 and lamp_r = 111100 one cycle later.
REQ-030 M1 = 10 and M4 = 10 held for 2 cycles -> fault = 1, fault_code = 1, and lamp_r toggles every 4 cycles.
REQ-031 Conflict present for 1 cycle only -> no fault, filter counter returns to 0.
REQ-032 M2 = 11 together with a conflict -> fault_code = 2.
REQ-033 With the macro defined, M1 goes 10 -> 00 and is held -> fault_code = 3; with the macro undefined -> no fault.
REQ-034 In FLASH, clr while the conflict persists -> stays in FLASH; clr after the conflict is removed -> RECOVER for 8 cycles, then NORMAL.
